// File: rtl/sat_ctrl_pkg.sv
// Shared definitions for the clause-array sequencer: command encoding and FSM state type.
package sat_ctrl_pkg;

  localparam logic [2:0] CMD_LOAD   = 3'd0;
  localparam logic [2:0] CMD_UNLOAD = 3'd1;
  localparam logic [2:0] CMD_LEARNT = 3'd2;
  localparam logic [2:0] CMD_IMPLY  = 3'd3;
  localparam logic [2:0] CMD_BKT    = 3'd4;

  localparam int unsigned StateW = 4;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StLoad,
    StRdReq,
    StRdWait,
    StRdOut,
    StLearnt,
    StImply,
    StBkt,
    StDone
  } state_e;

endpackage

// File: rtl/onehot_slot_dec.sv
// Binary slot index plus enable to a one-hot slot strobe vector.
module onehot_slot_dec #(
  parameter int unsigned NUM_SLOTS = 8,
  localparam int unsigned IdxW = $clog2(NUM_SLOTS)
) (
  input  logic [IdxW-1:0]      idx_i,
  input  logic                 en_i,
  output logic [NUM_SLOTS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/clause_array_ctrl.sv
// Clause array sequencer: load/unload clause streams, learnt insertion, implication loop and
// backtrack. All array-side strobes and data are registered.
module clause_array_ctrl
  import sat_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned WIDTH_C_LEN = 4,
  parameter int unsigned MAX_ITER    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [2:0]                     cmd_i,
  input  logic [$clog2(NUM_CLAUSES):0]   num_i,
  input  logic                           cl_valid_i,
  output logic                           cl_ready_o,
  input  logic [NUM_VARS*2-1:0]          cl_data_i,
  input  logic [WIDTH_C_LEN-1:0]         cl_len_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [NUM_VARS*2-1:0]          out_data_o,
  output logic [NUM_CLAUSES-1:0]         wr_o,
  output logic [NUM_CLAUSES-1:0]         rd_o,
  output logic [NUM_VARS*2-1:0]          clause_o,
  output logic [WIDTH_C_LEN-1:0]         clause_len_o,
  input  logic [NUM_VARS*2-1:0]          clause_i,
  output logic                           add_learntc_en_o,
  output logic                           apply_impl_o,
  output logic                           apply_bkt_o,
  input  logic [NUM_VARS*3-1:0]          var_value_i,
  input  logic                           all_c_sat_i,
  output logic                           done_o,
  output logic                           sat_o,
  output logic                           timeout_o
);

  localparam int unsigned SlotW = $clog2(NUM_CLAUSES);
  localparam int unsigned NumW  = SlotW + 1;
  localparam int unsigned IterW = $clog2(MAX_ITER + 1);
  localparam int unsigned ClW   = NUM_VARS * 2;
  localparam int unsigned VarW  = NUM_VARS * 3;
  localparam logic [NumW-1:0]  NumMax  = NumW'(NUM_CLAUSES);
  localparam logic [IterW-1:0] IterMax = IterW'(MAX_ITER);

  state_e state_q, state_d;

  logic [NumW-1:0]        slot_q, slot_d, num_q, num_d;
  logic [IterW-1:0]       iter_q, iter_d;
  logic [VarW-1:0]        snap_q, snap_d;
  logic [ClW-1:0]         out_data_q, out_data_d;
  logic [ClW-1:0]         clause_q, clause_d;
  logic [WIDTH_C_LEN-1:0] clause_len_q, clause_len_d;
  logic [NUM_CLAUSES-1:0] wr_q, wr_d, rd_q, rd_d;
  logic                   learnt_q, learnt_d;
  logic                   impl_q, impl_d;
  logic                   bkt_q, bkt_d;
  logic                   sat_q, sat_d;
  logic                   timeout_q, timeout_d;

  logic                   cmd_acc, cl_hs, out_hs, settled, last_slot, wr_en, rd_en;
  logic [NumW-1:0]        num_clamped, slot_inc;
  logic [SlotW-1:0]       rd_idx;

  // Gated by reset so every output, including the ready, reads 0 while reset is held.
  assign cmd_ready_o = (state_q == StIdle) && rst;
  assign cl_ready_o  = ((state_q == StLoad) && (slot_q < num_q)) ||
                       ((state_q == StLearnt) && !learnt_q);
  assign out_valid_o = (state_q == StRdOut);
  assign done_o      = (state_q == StDone);

  assign cmd_acc     = cmd_valid_i && cmd_ready_o;
  assign cl_hs       = cl_valid_i && cl_ready_o;
  assign out_hs      = out_valid_o && out_ready_i;
  assign settled     = (var_value_i == snap_q);
  assign num_clamped = (num_i > NumMax) ? NumMax : num_i;
  assign slot_inc    = slot_q + NumW'(1);
  assign last_slot   = (slot_inc == num_q);
  assign wr_en       = (state_q == StLoad) && cl_hs;

  onehot_slot_dec #(
    .NUM_SLOTS(NUM_CLAUSES)
  ) u_wr_dec (
    .idx_i   (slot_q[SlotW-1:0]),
    .en_i    (wr_en),
    .onehot_o(wr_d)
  );

  onehot_slot_dec #(
    .NUM_SLOTS(NUM_CLAUSES)
  ) u_rd_dec (
    .idx_i   (rd_idx),
    .en_i    (rd_en),
    .onehot_o(rd_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_acc) begin
          case (cmd_i)
            CMD_LOAD:   state_d = (num_clamped == '0) ? StDone : StLoad;
            CMD_UNLOAD: state_d = (num_clamped == '0) ? StDone : StRdReq;
            CMD_LEARNT: state_d = StLearnt;
            CMD_IMPLY:  state_d = StImply;
            CMD_BKT:    state_d = StBkt;
            default:    state_d = StDone;
          endcase
        end
      end
      StLoad:   if (slot_q == num_q) state_d = StDone;
      StRdReq:  state_d = StRdWait;
      StRdWait: state_d = StRdOut;
      StRdOut:  if (out_hs) state_d = last_slot ? StDone : StRdReq;
      StLearnt: if (learnt_q) state_d = StDone;
      // Strobe and compare cycles alternate; a compare cycle either finishes or re-strobes.
      StImply:  if (!impl_q && (settled || (iter_q == IterMax))) state_d = StDone;
      StBkt:    state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    slot_d       = slot_q;
    num_d        = num_q;
    iter_d       = iter_q;
    snap_d       = snap_q;
    out_data_d   = out_data_q;
    sat_d        = sat_q;
    timeout_d    = timeout_q;
    clause_d     = '0;
    clause_len_d = '0;
    learnt_d     = 1'b0;
    impl_d       = 1'b0;
    bkt_d        = 1'b0;
    rd_en        = 1'b0;
    rd_idx       = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_acc) begin
          slot_d = '0;
          num_d  = num_clamped;
          iter_d = '0;
          case (cmd_i)
            CMD_UNLOAD: rd_en = (num_clamped != '0);
            CMD_IMPLY: begin
              snap_d    = var_value_i;
              impl_d    = 1'b1;
              iter_d    = IterW'(1);
              sat_d     = 1'b0;
              timeout_d = 1'b0;
            end
            CMD_BKT: bkt_d = 1'b1;
            default: ;
          endcase
        end
      end
      StLoad, StLearnt: begin
        if (cl_hs) begin
          clause_d     = cl_data_i;
          clause_len_d = cl_len_i;
          if (state_q == StLoad) begin
            slot_d = slot_inc;
          end else begin
            learnt_d = 1'b1;
          end
        end
      end
      StRdWait: out_data_d = clause_i;
      StRdOut: begin
        if (out_hs) begin
          out_data_d = '0;
          slot_d     = slot_inc;
          if (!last_slot) begin
            rd_en  = 1'b1;
            rd_idx = slot_inc[SlotW-1:0];
          end
        end
      end
      StImply: begin
        if (!impl_q) begin
          if (settled) begin
            sat_d     = all_c_sat_i;
            timeout_d = 1'b0;
          end else if (iter_q == IterMax) begin
            sat_d     = all_c_sat_i;
            timeout_d = 1'b1;
          end else begin
            snap_d = var_value_i;
            impl_d = 1'b1;
            iter_d = iter_q + IterW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q       <= '0;
      num_q        <= '0;
      iter_q       <= '0;
      snap_q       <= '0;
      out_data_q   <= '0;
      clause_q     <= '0;
      clause_len_q <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      learnt_q     <= 1'b0;
      impl_q       <= 1'b0;
      bkt_q        <= 1'b0;
      sat_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      num_q        <= num_d;
      iter_q       <= iter_d;
      snap_q       <= snap_d;
      out_data_q   <= out_data_d;
      clause_q     <= clause_d;
      clause_len_q <= clause_len_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      learnt_q     <= learnt_d;
      impl_q       <= impl_d;
      bkt_q        <= bkt_d;
      sat_q        <= sat_d;
      timeout_q    <= timeout_d;
    end
  end

  assign out_data_o       = out_data_q;
  assign wr_o             = wr_q;
  assign rd_o             = rd_q;
  assign clause_o         = clause_q;
  assign clause_len_o     = clause_len_q;
  assign add_learntc_en_o = learnt_q;
  assign apply_impl_o     = impl_q;
  assign apply_bkt_o      = bkt_q;
  assign sat_o            = sat_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_clause_array_ctrl.sv
// Directed bench for clause_array_ctrl: reset, load, unload with stall, implication loop,
// learnt/backtrack sequencing and load clamping.
module tb_clause_array_ctrl;

  localparam logic [2:0] CLoad   = 3'd0;
  localparam logic [2:0] CUnload = 3'd1;
  localparam logic [2:0] CLearnt = 3'd2;
  localparam logic [2:0] CImply  = 3'd3;
  localparam logic [2:0] CBkt    = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o;
  logic [2:0]  cmd_i;
  logic [3:0]  num_i;
  logic        cl_valid_i, cl_ready_o;
  logic [15:0] cl_data_i;
  logic [3:0]  cl_len_i;
  logic        out_valid_o, out_ready_i;
  logic [15:0] out_data_o;
  logic [7:0]  wr_o, rd_o;
  logic [15:0] clause_o, clause_i;
  logic [3:0]  clause_len_o;
  logic        add_learntc_en_o, apply_impl_o, apply_bkt_o;
  logic [23:0] var_value_i;
  logic        all_c_sat_i, done_o, sat_o, timeout_o;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  clause_array_ctrl #(
    .NUM_CLAUSES(8),
    .NUM_VARS   (8),
    .WIDTH_C_LEN(4),
    .MAX_ITER   (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_i           (cmd_i),
    .num_i           (num_i),
    .cl_valid_i      (cl_valid_i),
    .cl_ready_o      (cl_ready_o),
    .cl_data_i       (cl_data_i),
    .cl_len_i        (cl_len_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_data_o      (out_data_o),
    .wr_o            (wr_o),
    .rd_o            (rd_o),
    .clause_o        (clause_o),
    .clause_len_o    (clause_len_o),
    .clause_i        (clause_i),
    .add_learntc_en_o(add_learntc_en_o),
    .apply_impl_o    (apply_impl_o),
    .apply_bkt_o     (apply_bkt_o),
    .var_value_i     (var_value_i),
    .all_c_sat_i     (all_c_sat_i),
    .done_o          (done_o),
    .sat_o           (sat_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && ($countones({|wr_o, |rd_o, add_learntc_en_o, apply_impl_o, apply_bkt_o}) > 1))
      overlap++;
  end

  function automatic logic [15:0] beat_data(input int i);
    return 16'h1234 + 16'(i) * 16'h1111;
  endfunction

  function automatic logic [3:0] beat_len(input int i);
    case (i)
      0: return 4'd2;
      1: return 4'd3;
      2: return 4'd1;
      default: return 4'(i);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a command in the current (idle) cycle; returns one cycle later.
  task automatic issue(input logic [2:0] c, input logic [3:0] n);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: cmd_ready_o=%b, required 1", cmd_ready_o);
    end
    cmd_valid_i = 1'b1;
    cmd_i       = c;
    num_i       = n;
    tick();
    cmd_valid_i = 1'b0;
    cmd_i       = 3'd0;
    num_i       = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready_o, cl_ready_o, out_valid_o, out_data_o, wr_o, rd_o, clause_o, clause_len_o,
         add_learntc_en_o, apply_impl_o, apply_bkt_o, done_o, sat_o, timeout_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b wr=%b rd=%b done=%b, required all 0",
               cmd_ready_o, wr_o, rd_o, done_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (cmd_ready_o !== 1'b1 || done_o !== 1'b0 || wr_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: ready=%b done=%b wr=%b, required 1 0 0",
               cmd_ready_o, done_o, wr_o);
    end
  endtask

  task automatic test_load(input int n_req, input int n_exp);
    int bi = 0, nw = 0, first_wr = -1, done_cyc = -1, ndone = 0;
    logic [7:0]  exp_wr;
    logic [15:0] exp_d;
    logic [3:0]  exp_l;
    issue(CLoad, 4'(n_req));
    for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
      if (wr_o != 8'h00) begin
        if (first_wr < 0) first_wr = cyc;
        exp_wr = (nw < n_exp) ? 8'(1 << nw) : 8'h00;
        exp_d  = beat_data(nw);
        exp_l  = beat_len(nw);
        checks++;
        if (wr_o !== exp_wr || clause_o !== exp_d || clause_len_o !== exp_l) begin
          errors++;
          $display("FAIL load_wr%0d: wr=%b data=%h len=%0d, required wr=%b data=%h len=%0d",
                   nw, wr_o, clause_o, clause_len_o, exp_wr, exp_d, exp_l);
        end
        nw++;
      end
      if (done_o) begin
        done_cyc = cyc;
        ndone++;
      end
      cl_valid_i = (bi < n_req);
      cl_data_i  = beat_data(bi);
      cl_len_i   = beat_len(bi);
      if (cl_valid_i && cl_ready_o) bi++;
      tick();
    end
    cl_valid_i = 1'b0;
    checks++;
    if (nw !== n_exp || first_wr !== 2) begin
      errors++;
      $display("FAIL load_count: writes=%0d first_at=%0d, required %0d at 2", nw, first_wr, n_exp);
    end
    checks++;
    if (done_cyc !== n_exp + 2 || ndone !== 1) begin
      errors++;
      $display("FAIL load_done: done at %0d (pulses %0d), required %0d (1)",
               done_cyc, ndone, n_exp + 2);
    end
  endtask

  task automatic test_unload();
    logic [15:0] mem [2];
    logic        rd_prev = 1'b0;
    int          rd_idx_prev = 0, nrd = 0, beat = 0, stall = 0;
    int          done_cyc = -1, beats_at_done = -1;
    logic [7:0]  exp_rd;
    logic [15:0] exp_d;
    mem[0] = 16'hC0DE;
    mem[1] = 16'hBEEF;
    out_ready_i = 1'b0;
    issue(CUnload, 4'd2);
    for (int cyc = 1; cyc <= 30 && done_cyc < 0; cyc++) begin
      clause_i = rd_prev ? mem[rd_idx_prev] : 16'h5A5A;
      rd_prev  = 1'b0;
      if (rd_o != 8'h00) begin
        exp_rd = (nrd < 2) ? 8'(1 << nrd) : 8'h00;
        checks++;
        if (rd_o !== exp_rd) begin
          errors++;
          $display("FAIL unload_rd%0d: rd=%b, required %b", nrd, rd_o, exp_rd);
        end
        rd_prev     = 1'b1;
        rd_idx_prev = (nrd > 1) ? 1 : nrd;
        nrd++;
      end
      out_ready_i = 1'b0;
      if (out_valid_o) begin
        exp_d = mem[(beat > 1) ? 1 : beat];
        checks++;
        if (out_data_o !== exp_d) begin
          errors++;
          $display("FAIL unload_data%0d: out_data=%h, required %h", beat, out_data_o, exp_d);
        end
        if (beat == 0 && stall < 4) begin
          stall++;
        end else begin
          out_ready_i = 1'b1;
          beat++;
        end
      end
      if (done_o) begin
        done_cyc      = cyc;
        beats_at_done = beat;
      end
      tick();
    end
    out_ready_i = 1'b0;
    checks++;
    if (nrd !== 2) begin
      errors++;
      $display("FAIL unload_rd_count: reads=%0d, required 2", nrd);
    end
    checks++;
    if (done_cyc !== 11 || beats_at_done !== 2) begin
      errors++;
      $display("FAIL unload_done: done at %0d after %0d beats, required 11 after 2",
               done_cyc, beats_at_done);
    end
  endtask

  task automatic test_imply(input int changes, input logic sat_in, input int exp_pulses,
                            input logic exp_sat, input logic exp_to, input string name);
    int left = changes, pulses = 0, done_cyc = -1;
    all_c_sat_i = sat_in;
    issue(CImply, 4'd0);
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      if (apply_impl_o) begin
        pulses++;
        if (left > 0) begin
          var_value_i = var_value_i + 24'h000111;
          left--;
        end
      end
      if (done_o) begin
        done_cyc = cyc;
        checks++;
        if (sat_o !== exp_sat || timeout_o !== exp_to) begin
          errors++;
          $display("FAIL %s_flags: sat=%b timeout=%b, required %b %b",
                   name, sat_o, timeout_o, exp_sat, exp_to);
        end
      end
      tick();
    end
    checks++;
    if (pulses !== exp_pulses) begin
      errors++;
      $display("FAIL %s_pulses: %0d strobes, required %0d", name, pulses, exp_pulses);
    end
    checks++;
    if (done_cyc !== 2 * exp_pulses + 1) begin
      errors++;
      $display("FAIL %s_done: done at %0d, required %0d", name, done_cyc, 2 * exp_pulses + 1);
    end
    checks++;
    if (sat_o !== exp_sat || timeout_o !== exp_to) begin
      errors++;
      $display("FAIL %s_hold: sat=%b timeout=%b after done, required %b %b",
               name, sat_o, timeout_o, exp_sat, exp_to);
    end
    all_c_sat_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic sent = 1'b0;
    int   beat_cyc = -1, nl = 0, nb = 0, done_cyc = -1, bkt_cyc = -1;
    issue(CLearnt, 4'd0);
    for (int cyc = 1; cyc <= 10 && done_cyc < 0; cyc++) begin
      if (add_learntc_en_o) begin
        nl++;
        checks++;
        if (wr_o !== 8'h00 || clause_o !== 16'h7777 || clause_len_o !== 4'd5 ||
            cyc !== beat_cyc + 1) begin
          errors++;
          $display("FAIL learnt_strobe: wr=%b data=%h len=%0d at %0d, required 0 7777 5 at %0d",
                   wr_o, clause_o, clause_len_o, cyc, beat_cyc + 1);
        end
      end
      if (done_o) done_cyc = cyc;
      cl_valid_i = !sent;
      cl_data_i  = 16'h7777;
      cl_len_i   = 4'd5;
      if (cl_valid_i && cl_ready_o) begin
        sent     = 1'b1;
        beat_cyc = cyc;
      end
      tick();
    end
    cl_valid_i = 1'b0;
    checks++;
    if (nl !== 1 || done_cyc !== beat_cyc + 2) begin
      errors++;
      $display("FAIL learnt_done: pulses=%0d done at %0d, required 1 at %0d",
               nl, done_cyc, beat_cyc + 2);
    end
    done_cyc = -1;
    issue(CBkt, 4'd0);
    for (int cyc = 1; cyc <= 10 && done_cyc < 0; cyc++) begin
      if (apply_bkt_o) begin
        nb++;
        bkt_cyc = cyc;
      end
      if (done_o) done_cyc = cyc;
      tick();
    end
    checks++;
    if (nb !== 1 || bkt_cyc !== 1 || done_cyc !== 2) begin
      errors++;
      $display("FAIL bkt_timing: pulses=%0d at %0d done at %0d, required 1 at 1 done at 2",
               nb, bkt_cyc, done_cyc);
    end
    test_load(9, 8);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    issue(CLoad, 4'd3);
    cl_valid_i = 1'b1;
    cl_data_i  = beat_data(0);
    cl_len_i   = beat_len(0);
    tick();
    checks++;
    if (wr_o !== 8'h01) begin
      errors++;
      $display("FAIL midrst_pre: wr=%b, required 00000001", wr_o);
    end
    rst = 1'b0;
    cl_valid_i = 1'b0;
    #1;
    checks++;
    if ({cmd_ready_o, cl_ready_o, out_valid_o, out_data_o, wr_o, rd_o, clause_o, clause_len_o,
         add_learntc_en_o, apply_impl_o, apply_bkt_o, done_o, sat_o, timeout_o} !== '0) begin
      errors++;
      $display("FAIL midrst_async: wr=%b data=%h len=%0d ready=%b, required all 0",
               wr_o, clause_o, clause_len_o, cmd_ready_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_o || !cmd_ready_o || wr_o != 8'h00) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midrst_after: %0d bad cycles (done/ready/wr), required 0", bad);
    end
  endtask

  initial begin
    rst         = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_i       = 3'd0;
    num_i       = 4'd0;
    cl_valid_i  = 1'b0;
    cl_data_i   = 16'h0000;
    cl_len_i    = 4'd0;
    out_ready_i = 1'b0;
    clause_i    = 16'h0000;
    var_value_i = 24'h000000;
    all_c_sat_i = 1'b0;

    test_reset();
    test_load(3, 3);
    test_unload();
    test_imply(2, 1'b1, 3, 1'b1, 1'b0, "imply_settle");
    test_imply(1000, 1'b0, 16, 1'b0, 1'b1, "imply_timeout");
    test_back_to_back();
    test_reset_mid();

    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL strobe_overlap: %0d cycles with multiple strobes, required 0", overlap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clause_array_ctrl.md
# clause_array_ctrl

Sequencer for the clause array of the SAT engine. It owns every array control strobe:
- loads clauses from an input stream into consecutive slots;
- streams stored clauses back out;
- issues learnt-clause insertion;
- runs the implication loop until the variable values settle, then applies backtrack.

It sits between the engine's top-level solver FSM (command port) and the clause array (array port).

## Interface
Parameters:
- NUM_CLAUSES, 8, clause slots in the array (power of two, ≥2)
- NUM_VARS, 8, variables per clause
- WIDTH_C_LEN, 4, clause-length field width
- MAX_ITER, 16, implication iteration limit (≥2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  controller idle, command accepted when both high
- cmd_i  in  3  0=LOAD, 1=UNLOAD, 2=LEARNT, 3=IMPLY, 4=BKT; others ignored (accepted, done_o pulse, no action)
- num_i  in  $clog2(NUM_CLAUSES)+1  clause count for LOAD/UNLOAD, sampled at acceptance
- cl_valid_i  in  1  input clause beat valid
- cl_ready_o  out  1  input clause beat accepted
- cl_data_i  in  NUM_VARS*2  input clause literals
- cl_len_i  in  WIDTH_C_LEN  input clause length
- out_valid_o  out  1  readback beat valid
- out_ready_i  in  1  readback beat consumed
- out_data_o  out  NUM_VARS*2  readback clause
- wr_o  out  NUM_CLAUSES  one-hot slot write strobe to array
- rd_o  out  NUM_CLAUSES  one-hot slot read strobe to array
- clause_o  out  NUM_VARS*2  clause data to array
- clause_len_o  out  WIDTH_C_LEN  clause length to array
- clause_i  in  NUM_VARS*2  array read data, valid the cycle after rd_o
- add_learntc_en_o  out  1  learnt insertion enable to array
- apply_impl_o  out  1  implication strobe to array
- apply_bkt_o  out  1  backtrack strobe to array
- var_value_i  in  NUM_VARS*3  array variable values
- all_c_sat_i  in  1  array all-clauses-satisfied flag
- done_o  out  1  one-cycle pulse at command completion
- sat_o  out  1  all_c_sat_i captured at IMPLY completion, held until next IMPLY
- timeout_o  out  1  IMPLY hit MAX_ITER, held until next IMPLY

## Operation
- States: IDLE, LOAD, RD_REQ, RD_WAIT, RD_OUT, LEARNT, IMPLY, BKT, DONE.
- Every array-side output is registered. All outputs are 0 in reset and in IDLE. cmd_ready_o is 1 only in IDLE.
- LOAD:
  - Slot counter starts at 0. cl_ready_o=1 while slot < num.
  - A beat handshaken in cycle t drives wr_o[slot], clause_o and clause_len_o in cycle t+1; slot then increments.
  - num=0 goes straight to DONE.
  - num>NUM_CLAUSES is clamped to NUM_CLAUSES.
- UNLOAD:
  - RD_REQ drives rd_o[slot] for one cycle.
  - RD_WAIT captures clause_i into out_data_o.
  - RD_OUT holds out_valid_o until out_ready_i. Then it goes to the next slot, or to DONE after slot num-1.
  - One read is outstanding at a time. out_data_o is stable while out_valid_o && !out_ready_i.
  - num=0 or num>NUM_CLAUSES: same rules as LOAD.
- LEARNT:
  - Waits for one cl_valid_i beat (cl_ready_o=1).
  - The next cycle drives add_learntc_en_o=1 with clause_o/clause_len_o. The array chooses the slot; wr_o stays 0.
- IMPLY:
  - Raises apply_impl_o for one cycle per iteration.
  - The cycle after each strobe, var_value_i is compared with the snapshot taken before that strobe.
  - Equal: DONE with sat_o=all_c_sat_i and timeout_o=0.
  - Unequal: take a new snapshot and strobe again.
  - The iteration counter (width $clog2(MAX_ITER+1)) reaching MAX_ITER ends the command with timeout_o=1 and sat_o=all_c_sat_i.
  - The first snapshot is taken in the acceptance cycle.
- BKT: one cycle of apply_bkt_o, then DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Reset asserted mid-command: all strobes drop asynchronously, the FSM returns to IDLE, and the partial load is abandoned with no completion pulse.

## Timing
- Command accepted at cycle t: first state action at t+1.
- BKT: apply_bkt_o at t+1, done_o at t+2.
- LEARNT with a beat at cycle u: add_learntc_en_o at u+1, done_o at u+2.
- LOAD of n clauses with continuous cl_valid_i: wr_o in cycles t+2..t+n+1; done_o at t+n+2.
- UNLOAD with out_ready_i tied high: 3 cycles per clause, plus 1 for DONE.
- IMPLY settling after k strobes: 2k cycles, plus 1 for DONE.
- wr_o, rd_o, add_learntc_en_o, apply_impl_o and apply_bkt_o are mutually exclusive in every cycle.

## Structure
- Shared package sat_ctrl_pkg holds the command encoding constants (CMD_LOAD..CMD_BKT) and the state enum width.
- One natural sub-module, onehot_slot_dec: binary slot index plus enable to NUM_CLAUSES one-hot, used for both wr_o and rd_o.

## Test plan
- Reset: rst=0 during activity → all outputs 0 immediately; after release cmd_ready_o=1.
- LOAD num=3 with beats A,B,C (lengths 2,3,1) → wr_o=00000001,00000010,00000100 on consecutive cycles with matching clause_o/clause_len_o; one done_o.
- UNLOAD num=2 with out_ready_i low for 4 cycles on beat 0 → rd_o=00000001 exactly once; out_data_o stable while stalled; then rd_o=00000010; done_o after second handshake.
- IMPLY, model array changes var_value on strobes 1–2, then stable with all_c_sat=1 → 3 apply_impl_o pulses; done_o; sat_o=1, timeout_o=0.
- IMPLY, model never stabilises, MAX_ITER=16 → exactly 16 pulses; timeout_o=1.
- LEARNT then BKT back-to-back → add_learntc_en_o one cycle with wr_o=0; apply_bkt_o one cycle; no two strobes overlap; LOAD num=9 clamps to 8 writes.
